// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core, loader) arbiter onto a single-ported data memory.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester that is not granted holds req/we/addr/wdata until its gnt; there are no response stalls.
//
// Ports:
//   clk, rst                           - clock (rising edge), asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata -> c_gnt - core request, granted combinationally
//   c_rvalid/c_rdata                   - core read response, one cycle after a read grant
//   l_req/l_we/l_addr/l_wdata -> l_gnt - loader request, granted combinationally
//   l_rvalid/l_rdata                   - loader read response, one cycle after a read grant
//   l_lock                             - loader burst lock (only with DMEM_ARB_LOCK_EN)
//   m_en/m_we/m_addr/m_wdata, m_rdata  - memory access port
//
// Build option: define DMEM_ARB_LOCK_EN to add the loader burst lock (LOCKED state, l_lock
// port, lock counter). Without it arbitration is pure round-robin.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          l_lock,
`endif
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    // A zero lock budget would let the core in on every locked cycle, defeating the lock.
    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("dmem_arbiter: LOCK_MAX must be at least 1");
    end

    // State names the owner of the previous cycle's grant.
`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CORE   = 2'd1,
        ST_LOADER = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CORE   = 2'd1,
        ST_LOADER = 2'd2
    } state_e;
`endif

    state_e state_q, state_d;
    logic   ptr_q, ptr_d;     // contention winner: 0 = core, 1 = loader
    logic   rv_q, rv_d;       // a read response is due this cycle
    logic   c_win, l_win;
    logic   resp_own;         // 1 = pending response belongs to the loader

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_full;

    // LOCKED can follow a core grant (budget release), so the state alone
    // cannot say who owns the response; keep a dedicated owner flop.
    assign lock_full = (cnt_q == CW'(LOCK_MAX));
    assign resp_own  = own_q;
`else
    // Without the lock the state register is exactly the previous grant owner.
    assign resp_own = (state_q == ST_LOADER);
`endif

    // Grant selection. Gated by rst so every output is 0 while reset is held.
    always_comb begin
        c_win = 1'b0;
        l_win = 1'b0;
        if (rst) begin
`ifdef DMEM_ARB_LOCK_EN
            if (state_q == ST_LOCKED) begin
                // Loader owns the memory; the core only gets in once the budget is used up.
                if (lock_full && c_req) begin
                    c_win = 1'b1;
                end else begin
                    l_win = l_req;
                end
            end else
`endif
            begin
                if (c_req && (!l_req || !ptr_q)) begin
                    c_win = 1'b1;
                end else if (l_req) begin
                    l_win = 1'b1;
                end
            end
        end
    end

    assign c_gnt = c_win;
    assign l_gnt = l_win;

    // Memory port mux; address/data forced to 0 when idle.
    always_comb begin
        m_en    = c_win | l_win;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_win) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (l_win) begin
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    assign c_rvalid = rv_q & ~resp_own;
    assign l_rvalid = rv_q & resp_own;
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign l_rdata  = l_rvalid ? m_rdata : '0;

    // Next state, pointer and response tracking.
    always_comb begin
        state_d = ST_IDLE;
        ptr_d   = ptr_q;
        rv_d    = (c_win | l_win) & ~m_we;
`ifdef DMEM_ARB_LOCK_EN
        own_d   = l_win;
        cnt_d   = '0;
`endif
        if (c_win) begin
            ptr_d   = 1'b1;
            state_d = ST_CORE;
`ifdef DMEM_ARB_LOCK_EN
            // Budget release: go straight back to LOCKED if the burst is still on.
            if (state_q == ST_LOCKED && l_req && l_lock) begin
                state_d = ST_LOCKED;
            end
`endif
        end else if (l_win) begin
            ptr_d   = 1'b0;
            state_d = ST_LOADER;
`ifdef DMEM_ARB_LOCK_EN
            if (l_lock) begin
                state_d = ST_LOCKED;
                cnt_d   = lock_full ? cnt_q : cnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            rv_q    <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            own_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rv_q    <= rv_d;
`ifdef DMEM_ARB_LOCK_EN
            own_q   <= own_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Latency: inputs applied just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: requesters hold their request until the model predicts a grant.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 16;
    localparam int N_RAND   = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          l_req, l_we, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic          l_lock = 1'b0;
`endif
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
`ifdef DMEM_ARB_LOCK_EN
        .l_lock   (l_lock),
`endif
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_c_gnt"},    c_gnt,    0);
        chk_eq({tag, "_c_rvalid"}, c_rvalid, 0);
        chk_eq({tag, "_c_rdata"},  c_rdata,  0);
        chk_eq({tag, "_l_gnt"},    l_gnt,    0);
        chk_eq({tag, "_l_rvalid"}, l_rvalid, 0);
        chk_eq({tag, "_l_rdata"},  l_rdata,  0);
        chk_eq({tag, "_m_en"},     m_en,     0);
        chk_eq({tag, "_m_we"},     m_we,     0);
        chk_eq({tag, "_m_addr"},   m_addr,   0);
        chk_eq({tag, "_m_wdata"},  m_wdata,  0);
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        m_rdata = '0;
`ifdef DMEM_ARB_LOCK_EN
        l_lock = 1'b0;
`endif
    endtask

    // Returns just after a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addr_tab [4];
        // ---------------- reset state: outputs 0 even with requests present
        idle_inputs();
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h44; c_wdata = 32'h99;
        l_req = 1'b1; l_addr = 32'h88;
        m_rdata = 32'hFFFF_FFFF;
        #1;
        chk_all_zero("rst");
        do_reset();

        // ---------------- core read of 0x10 on the first edge after release
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        #1;
        chk_eq("rd_c_gnt", c_gnt, 1);
        chk_eq("rd_l_gnt", l_gnt, 0);
        chk_eq("rd_m_en", m_en, 1);
        chk_eq("rd_m_we", m_we, 0);
        chk_eq("rd_m_addr", m_addr, 32'h10);
        chk_eq("rd_c_rvalid0", c_rvalid, 0);
        @(negedge clk);
        c_req = 1'b0; m_rdata = 32'hDEAD_BEEF;
        #1;
        chk_eq("rd_c_rvalid", c_rvalid, 1);
        chk_eq("rd_c_rdata", c_rdata, 32'hDEAD_BEEF);
        chk_eq("rd_l_rvalid", l_rvalid, 0);
        chk_eq("rd_l_rdata", l_rdata, 0);
        chk_eq("rd_m_en_idle", m_en, 0);
        @(negedge clk);
        #1;
        chk_eq("rd_c_rvalid_once", c_rvalid, 0);

        // ---------------- both ports request for 4 cycles after reset: C,L,C,L
        do_reset();
        addr_tab[0] = 32'h100; addr_tab[1] = 32'h200;
        addr_tab[2] = 32'h104; addr_tab[3] = 32'h204;
        for (int i = 0; i < 4; i++) begin
            c_req = 1'b1; c_we = 1'b0; c_addr = (i < 1) ? 32'h100 : (i < 3) ? 32'h104 : 32'h108;
            l_req = 1'b1; l_we = 1'b0; l_addr = (i < 2) ? 32'h200 : 32'h204;
            m_rdata = 32'hA000_0000 + 32'(i);
            #1;
            chk_eq($sformatf("rr_c_gnt%0d", i), c_gnt, (i % 2 == 0));
            chk_eq($sformatf("rr_l_gnt%0d", i), l_gnt, (i % 2 == 1));
            chk_eq($sformatf("rr_m_addr%0d", i), m_addr, addr_tab[i]);
            if (i > 0) begin
                chk_eq($sformatf("rr_c_rvalid%0d", i), c_rvalid, (i % 2 == 1));
                chk_eq($sformatf("rr_l_rvalid%0d", i), l_rvalid, (i % 2 == 0));
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        // ---------------- loader write 0x55 @0x20, then core read @0x20
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h55;
        #1;
        chk_eq("wr_l_gnt", l_gnt, 1);
        chk_eq("wr_m_we", m_we, 1);
        chk_eq("wr_m_addr", m_addr, 32'h20);
        chk_eq("wr_m_wdata", m_wdata, 32'h55);
        @(negedge clk);
        l_req = 1'b0; l_we = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
        #1;
        chk_eq("wr_c_gnt", c_gnt, 1);
        chk_eq("wr_m_we1", m_we, 0);
        chk_eq("wr_m_addr1", m_addr, 32'h20);
        chk_eq("wr_l_rvalid1", l_rvalid, 0);
        chk_eq("wr_c_rvalid1", c_rvalid, 0);
        @(negedge clk);
        c_req = 1'b0; m_rdata = 32'h55;
        #1;
        chk_eq("wr_c_rvalid2", c_rvalid, 1);
        chk_eq("wr_c_rdata2", c_rdata, 32'h55);
        chk_eq("wr_l_rvalid2", l_rvalid, 0);
        @(negedge clk);

        // ---------------- reset while a read response is pending
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30; m_rdata = 32'h1234_5678;
        #1;
        chk_eq("ar_c_gnt", c_gnt, 1);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("ar");
        @(negedge clk);
        rst = 1'b1; c_req = 1'b0;
        #1;
        chk_eq("ar_c_rvalid_rel", c_rvalid, 0);
        chk_eq("ar_c_rdata_rel", c_rdata, 0);
        @(negedge clk);
        #1;
        chk_eq("ar_c_rvalid_rel2", c_rvalid, 0);

`ifdef DMEM_ARB_LOCK_EN
        // ---------------- locked burst of 20 loader requests with the core waiting
        begin
            int seq[$];
            int l_sent;
            int first_c;
            do_reset();
            l_sent = 0;
            for (int i = 0; i < 40; i++) begin
                l_req = (l_sent < 20); l_we = 1'b0; l_lock = 1'b1;
                l_addr = 32'h1000 + 32'(l_sent) * 4;
                c_req = (i >= 1); c_we = 1'b0; c_addr = 32'h40;
                #1;
                if (l_gnt) begin
                    seq.push_back(2);
                    l_sent++;
                end else if (c_gnt) begin
                    seq.push_back(1);
                end
                @(negedge clk);
            end
            first_c = -1;
            foreach (seq[k]) if (first_c < 0 && seq[k] == 1) first_c = k;
            chk_eq("lk_l_before_c", first_c, LOCK_MAX);
            chk_eq("lk_resume", (seq.size() > LOCK_MAX + 1) ? seq[LOCK_MAX + 1] : 0, 2);
            chk_eq("lk_l_total", l_sent, 20);
            idle_inputs();
        end
`endif

        // ---------------- randomized traffic against the behavioural model
        begin
            int  fav;           // port favoured on contention: 0 core, 1 loader
            bit  pend;          // read response due this cycle
            int  pend_owner;    // 0 core, 1 loader
            bit  c_done, l_done;
            int  win;           // 0 none, 1 core, 2 loader
            logic          e_we;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wdata;
`ifdef DMEM_ARB_LOCK_EN
            bit  locked;
            int  run;
            locked = 0; run = 0;
`endif
            do_reset();
            fav = 0; pend = 0; pend_owner = 0;
            c_done = 1; l_done = 1;
            for (int i = 0; i < N_RAND; i++) begin
                if (!c_req || c_done) begin
                    c_req = ($urandom_range(0, 2) != 0);
                    c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
                end
                if (!l_req || l_done) begin
                    l_req = ($urandom_range(0, 2) != 0);
                    l_we = 1'($urandom); l_addr = $urandom; l_wdata = $urandom;
`ifdef DMEM_ARB_LOCK_EN
                    l_lock = ($urandom_range(0, 3) != 0);
`endif
                end
                m_rdata = $urandom;
                #1;
                win = 0;
`ifdef DMEM_ARB_LOCK_EN
                if (locked) begin
                    if (run >= LOCK_MAX && c_req) win = 1;
                    else if (l_req) win = 2;
                end else
`endif
                begin
                    if (c_req && l_req) win = (fav == 0) ? 1 : 2;
                    else if (c_req) win = 1;
                    else if (l_req) win = 2;
                end
                e_we    = (win == 1) ? c_we : (win == 2) ? l_we : 1'b0;
                e_addr  = (win == 1) ? c_addr : l_addr;
                e_wdata = (win == 1) ? c_wdata : l_wdata;
                chk_eq("rnd_c_gnt", c_gnt, (win == 1));
                chk_eq("rnd_l_gnt", l_gnt, (win == 2));
                chk_eq("rnd_m_en", m_en, (win != 0));
                chk_eq("rnd_m_we", m_we, e_we);
                if (win != 0) begin
                    chk_eq("rnd_m_addr", m_addr, e_addr);
                    chk_eq("rnd_m_wdata", m_wdata, e_wdata);
                end
                chk_eq("rnd_c_rvalid", c_rvalid, pend && pend_owner == 0);
                chk_eq("rnd_l_rvalid", l_rvalid, pend && pend_owner == 1);
                chk_eq("rnd_c_rdata", c_rdata, (pend && pend_owner == 0) ? m_rdata : '0);
                chk_eq("rnd_l_rdata", l_rdata, (pend && pend_owner == 1) ? m_rdata : '0);
                // model update
                pend       = (win != 0) && !e_we;
                pend_owner = (win == 2) ? 1 : 0;
                if (win == 1) fav = 1;
                if (win == 2) fav = 0;
`ifdef DMEM_ARB_LOCK_EN
                if (win == 1) begin
                    locked = locked && l_req && l_lock;
                    run = 0;
                end else if (win == 2 && l_lock) begin
                    locked = 1;
                    run = (run + 1 > LOCK_MAX) ? LOCK_MAX : run + 1;
                end else begin
                    locked = 0;
                    run = 0;
                end
`endif
                c_done = (win == 1);
                l_done = (win == 2);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, meaning the maximum consecutive locked loader grants.
REQ-004 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have core request ports c_req, c_we (in, 1), c_addr (in, AW) and c_wdata (in, DW).
REQ-007 The block SHALL have core response ports c_gnt, c_rvalid (out, 1) and c_rdata (out, DW).
REQ-008 The block SHALL have loader request ports l_req, l_we (in, 1), l_addr (in, AW) and l_wdata (in, DW).
REQ-009 The block SHALL have loader response ports l_gnt, l_rvalid (out, 1) and l_rdata (out, DW).
REQ-010 The block SHALL have port l_lock  in  1  loader burst-lock request (present only per REQ-031).
REQ-011 The block SHALL have memory request ports m_en, m_we (out, 1), m_addr (out, AW) and m_wdata (out, DW).
REQ-012 The block SHALL have port m_rdata  in  DW  read data, valid one cycle after a read access.

Function
REQ-013 The block SHALL grant at most one requester per cycle; x_gnt is combinational from x_req, the state and the priority pointer.
REQ-014 In a grant cycle, m_en SHALL be 1 and m_we/m_addr/m_wdata SHALL equal the granted requester's inputs; when no grant occurs, m_en SHALL be 0 and m_we SHALL be 0.
REQ-015 A requester SHALL hold req, we, addr and wdata stable until gnt; the block SHALL NOT depend on values after the grant cycle.
REQ-016 For a granted read, x_rvalid SHALL pulse exactly one cycle after the grant, with x_rdata = m_rdata in that cycle.
REQ-017 Granted writes SHALL produce no rvalid; the non-owner's rvalid SHALL stay 0, and x_rdata SHALL be 0 when x_rvalid is 0.
REQ-018 Back-to-back grants SHALL be allowed every cycle, with response routing tracked by a registered owner/valid pair.
REQ-019 A single requesting port SHALL be granted regardless of the priority pointer.
REQ-020 When both ports request, the port selected by the 1-bit pointer SHALL win; the pointer SHALL flip to the other port after any grant (round-robin).
REQ-021 FSM states SHALL be IDLE, CORE, LOADER and LOCKED, where the state names the owner of the previous cycle's grant: IDLE→CORE/LOADER on grant; any→IDLE with no grant.
REQ-022 The loser of a contended cycle SHALL be granted in the next cycle if it is still requesting.

Reset
REQ-023 On rst=0, all outputs SHALL be 0 asynchronously, with state=IDLE, pointer=core and lock counter=0.
REQ-024 Reset asserted with a read response pending SHALL drop the response, leaving no rvalid after release.
REQ-025 The first rising clk edge after release SHALL be able to grant.

Configuration
REQ-026 The macro DMEM_ARB_LOCK_EN SHALL enable the loader burst lock.
REQ-027 With DMEM_ARB_LOCK_EN defined, a loader grant with l_lock=1 SHALL enter LOCKED, and while LOCKED the loader SHALL have absolute priority and the core SHALL NOT be granted.
REQ-028 With DMEM_ARB_LOCK_EN defined, LOCKED SHALL exit to the normal states when the loader is granted with l_lock=0, or when l_req=0 for one cycle.
REQ-029 With DMEM_ARB_LOCK_EN defined, a counter SHALL increment per locked grant; at LOCK_MAX with c_req=1 the core SHALL be granted for one cycle, after which the counter SHALL clear and LOCKED SHALL resume if l_lock is still 1.
REQ-030 The lock counter SHALL saturate and SHALL NOT wrap.
REQ-031 Without DMEM_ARB_LOCK_EN, the l_lock port, the LOCKED state and the counter SHALL be absent, and arbitration SHALL be pure round-robin.

Verification
REQ-032 The bench SHALL cover: core read addr 0x10, memory returns 0xDEADBEEF -> c_gnt same cycle, c_rvalid=1 with c_rdata=0xDEADBEEF next cycle, l_rvalid=0.
REQ-033 The bench SHALL cover: both ports request continuously for 4 cycles after reset -> grants C,L,C,L with m_addr alternating accordingly.
REQ-034 The bench SHALL cover: loader write 0x55 to addr 0x20, then immediate core read of 0x20 -> m_we=1 in cycle 0, m_we=0 in cycle 1, and only c_rvalid pulses.
REQ-035 The bench SHALL cover: core read granted, then rst=0 before the next edge -> c_rvalid stays 0 and all outputs are 0 immediately.
REQ-036 The bench SHALL cover (lock enabled): l_lock=1 with 20 loader requests and core requesting -> 16 loader grants, 1 core grant, then loader grants resume.
